// File: rtl/bvb_bank_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bvb_bank_sched_pkg
// Description : Shared sizing constants, FSM state encoding and ID decode
//               helpers for the banked-vector-buffer bank scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bvb_bank_sched_pkg;

    localparam int CHANNEL_NUM = 4;
    localparam int COL_ID_SIZE = 10;
    localparam int BANK_BITS   = 2;
    localparam int BANK_LSB    = 7;
    localparam int BANK_NUM    = 2 ** BANK_BITS;
    localparam int CNT_W       = 16;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } sched_state_e;

    // Bank select field of a column ID.
    function automatic logic [BANK_BITS-1:0] id_bank(input logic [COL_ID_SIZE-1:0] col_id);
        return col_id[BANK_LSB +: BANK_BITS];
    endfunction

    // Row offset inside the selected bank.
    function automatic logic [BANK_LSB-1:0] id_offset(input logic [COL_ID_SIZE-1:0] col_id);
        return col_id[BANK_LSB-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bvb_bank_sched_arb.sv
`default_nettype none
// ============================================================================
// Module      : bvb_rr_arbiter
// Description : Round-robin arbiter with N requesters. The grant goes to the
//               first requester at or after the pointer (wrapping modulo N);
//               the pointer then moves just past the grantee. N need not be a
//               power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module bvb_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [CW-1:0] cand;
    logic          found;

    // Scan requesters starting at the pointer; the extra candidate bit lets
    // ptr+i exceed N before the single-subtract wrap.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found                = 1'b1;
                grant[cand[PW-1:0]]  = 1'b1;
                ptr_d = (cand[PW-1:0] == PW'(N - 1)) ? '0 : cand[PW-1:0] + PW'(1);
            end
        end
        if (clr) begin
            ptr_d = '0;
        end
    end

    // Pointer register; holds whenever nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bvb_bank_sched.sv
`default_nettype none
// ============================================================================
// Module      : bvb_bank_sched
// Description : Per-cycle bank scheduler. Maps each channel's head column ID
//               to a bank, arbitrates per bank (round robin), pops granted
//               IDs, drives one registered read address per bank and, two
//               cycles after the grant, tells the output mux which bank feeds
//               which channel. Supports vector-FIFO back-pressure and a
//               flush/drain sequence that resets the arbitration pointers.
//               Optional: define BVB_SCHED_STATS_EN to build the per-bank
//               saturating conflict counters (otherwise conflict_cnt is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module bvb_bank_sched
    import bvb_bank_sched_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNEL_NUM*COL_ID_SIZE-1:0] id,
    input  logic [CHANNEL_NUM-1:0]           id_fifo_empty,
    output logic [CHANNEL_NUM-1:0]           id_fifo_read,
    input  logic [CHANNEL_NUM-1:0]           vec_fifo_afull,
    output logic [BANK_NUM-1:0]              bank_en,
    output logic [BANK_NUM*BANK_LSB-1:0]     bank_addr,
    output logic [CHANNEL_NUM-1:0]           route_valid,
    output logic [CHANNEL_NUM*BANK_BITS-1:0] route_bank,
    input  logic                             flush,
    output logic                             flush_done,
    output logic [BANK_NUM*CNT_W-1:0]        conflict_cnt
);

    logic [CHANNEL_NUM-1:0][BANK_BITS-1:0]  ch_bank;
    logic [CHANNEL_NUM-1:0][BANK_LSB-1:0]   ch_off;
    logic [CHANNEL_NUM-1:0]                 req;
    logic [CHANNEL_NUM-1:0]                 grant;
    logic [BANK_NUM-1:0][CHANNEL_NUM-1:0]   bank_req;
    logic [BANK_NUM-1:0][CHANNEL_NUM-1:0]   bank_grant;

    sched_state_e                           state_q, state_d;
    logic                                   drained;
    logic                                   ptr_clr;

    logic [BANK_NUM-1:0]                    bank_en_q, bank_en_d;
    logic [BANK_NUM-1:0][BANK_LSB-1:0]      bank_addr_q, bank_addr_d;
    logic [CHANNEL_NUM-1:0]                 s1_valid_q, s1_valid_d;
    logic [CHANNEL_NUM-1:0][BANK_BITS-1:0]  s1_bank_q, s1_bank_d;
    logic [CHANNEL_NUM-1:0]                 route_valid_q, route_valid_d;
    logic [CHANNEL_NUM-1:0][BANK_BITS-1:0]  route_bank_q, route_bank_d;
    logic                                   flush_done_q, flush_done_d;

    // Only the bank and offset fields of an ID matter here.
    logic [CHANNEL_NUM*COL_ID_SIZE-1:0]     unused_id;
    assign unused_id = id;

    // Decode head IDs and build per-bank request vectors. Requests are
    // suppressed during reset so nothing is popped while the pipe is cleared.
    always_comb begin
        ch_bank  = '0;
        ch_off   = '0;
        req      = '0;
        bank_req = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            ch_bank[c] = id_bank(id[c*COL_ID_SIZE +: COL_ID_SIZE]);
            ch_off[c]  = id_offset(id[c*COL_ID_SIZE +: COL_ID_SIZE]);
            req[c]     = !id_fifo_empty[c] && !vec_fifo_afull[c] &&
                         (state_q == ST_RUN) && !flush && !rst;
        end
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                bank_req[b][c] = req[c] && (ch_bank[c] == BANK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank_arb
        bvb_rr_arbiter #(
            .N (CHANNEL_NUM)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .clr   (ptr_clr),
            .req   (bank_req[b]),
            .grant (bank_grant[b])
        );
    end

    // Fold bank grants into per-channel pops, bank enables/addresses and the
    // stage-1 routing information that follows the read by one cycle.
    always_comb begin
        grant       = '0;
        bank_en_d   = '0;
        bank_addr_d = '0;
        s1_bank_d   = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_en_d[b] = |bank_grant[b];
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                if (bank_grant[b][c]) begin
                    grant[c]       = 1'b1;
                    bank_addr_d[b] = ch_off[c];
                end
            end
        end
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            s1_bank_d[c] = grant[c] ? ch_bank[c] : '0;
        end
        s1_valid_d    = grant;
        route_valid_d = s1_valid_q;
        route_bank_d  = s1_bank_q;
    end

    // RUN/FLUSH control: drain both pipeline stages, then clear pointers and
    // pulse flush_done as the scheduler returns to RUN.
    always_comb begin
        state_d      = state_q;
        ptr_clr      = 1'b0;
        flush_done_d = 1'b0;
        drained      = (s1_valid_q == '0) && (route_valid_q == '0);
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (drained) begin
                    state_d      = ST_RUN;
                    ptr_clr      = 1'b1;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, bank-read stage and routing stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            bank_en_q     <= '0;
            bank_addr_q   <= '0;
            s1_valid_q    <= '0;
            s1_bank_q     <= '0;
            route_valid_q <= '0;
            route_bank_q  <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_en_q     <= bank_en_d;
            bank_addr_q   <= bank_addr_d;
            s1_valid_q    <= s1_valid_d;
            s1_bank_q     <= s1_bank_d;
            route_valid_q <= route_valid_d;
            route_bank_q  <= route_bank_d;
            flush_done_q  <= flush_done_d;
        end
    end

`ifdef BVB_SCHED_STATS_EN
    logic [BANK_NUM-1:0][CNT_W-1:0] conflict_q, conflict_d;

    // Count cycles in which two or more channels contend for a bank.
    always_comb begin
        conflict_d = conflict_q;
        for (int b = 0; b < BANK_NUM; b++) begin
            if ((state_q == ST_RUN) && ($countones(bank_req[b]) >= 2) &&
                (conflict_q[b] != {CNT_W{1'b1}})) begin
                conflict_d[b] = conflict_q[b] + CNT_W'(1);
            end
        end
    end

    // Counters are cleared by reset only, never by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

    assign id_fifo_read = grant;
    assign bank_en      = bank_en_q;
    assign bank_addr    = bank_addr_q;
    assign route_valid  = route_valid_q;
    assign route_bank   = route_bank_q;
    assign flush_done   = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bvb_bank_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bvb_bank_sched
// Description : Self-checking bench for bvb_bank_sched: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bvb_bank_sched;
    import bvb_bank_sched_pkg::*;

    localparam int NC = CHANNEL_NUM;
    localparam int NB = BANK_NUM;
`ifdef BVB_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NC*COL_ID_SIZE-1:0] id;
    logic [NC-1:0]             id_fifo_empty;
    logic [NC-1:0]             id_fifo_read;
    logic [NC-1:0]             vec_fifo_afull;
    logic [NB-1:0]             bank_en;
    logic [NB*BANK_LSB-1:0]    bank_addr;
    logic [NC-1:0]             route_valid;
    logic [NC*BANK_BITS-1:0]   route_bank;
    logic                      flush;
    logic                      flush_done;
    logic [NB*CNT_W-1:0]       conflict_cnt;

    always #5 clk = ~clk;

    bvb_bank_sched dut (
        .clk            (clk),
        .rst            (rst),
        .id             (id),
        .id_fifo_empty  (id_fifo_empty),
        .id_fifo_read   (id_fifo_read),
        .vec_fifo_afull (vec_fifo_afull),
        .bank_en        (bank_en),
        .bank_addr      (bank_addr),
        .route_valid    (route_valid),
        .route_bank     (route_bank),
        .flush          (flush),
        .flush_done     (flush_done),
        .conflict_cnt   (conflict_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- behavioural model ----------------
    int            m_ptr[NB];
    bit            m_in_flush;
    logic [NC-1:0] m_s1_v, m_rv;
    int            m_s1_b[NC], m_rb[NC];
    logic [NB-1:0] m_en;
    int            m_addr[NB];
    logic          m_done;
    int            m_cnt[NB];
    logic [NC-1:0] e_read;
    int            e_gch[NB];
    int            e_ncand[NB];

    function automatic int id_of(int c);
        return int'(id[c*COL_ID_SIZE +: COL_ID_SIZE]);
    endfunction
    function automatic int bank_of(int c);
        return (id_of(c) >> BANK_LSB) % NB;
    endfunction
    function automatic int off_of(int c);
        return id_of(c) % (1 << BANK_LSB);
    endfunction
    function automatic bit can_req(int c);
        return !id_fifo_empty[c] && !vec_fifo_afull[c] && !m_in_flush && !flush && !rst;
    endfunction

    function automatic logic [NB*BANK_LSB-1:0] exp_addr();
        logic [NB*BANK_LSB-1:0] r = '0;
        for (int b = 0; b < NB; b++) r[b*BANK_LSB +: BANK_LSB] = BANK_LSB'(m_addr[b]);
        return r;
    endfunction
    function automatic logic [NC*BANK_BITS-1:0] exp_rb();
        logic [NC*BANK_BITS-1:0] r = '0;
        for (int c = 0; c < NC; c++) r[c*BANK_BITS +: BANK_BITS] = BANK_BITS'(m_rb[c]);
        return r;
    endfunction
    function automatic logic [NB*CNT_W-1:0] exp_cnt();
        logic [NB*CNT_W-1:0] r = '0;
        for (int b = 0; b < NB; b++) r[b*CNT_W +: CNT_W] = CNT_W'(m_cnt[b]);
        return r;
    endfunction

    task automatic reset_model();
        m_in_flush = 1'b0;
        m_s1_v = '0; m_rv = '0; m_en = '0; m_done = 1'b0;
        for (int c = 0; c < NC; c++) begin m_s1_b[c] = 0; m_rb[c] = 0; end
        for (int b = 0; b < NB; b++) begin m_ptr[b] = 0; m_addr[b] = 0; m_cnt[b] = 0; end
    endtask

    // Work out this cycle's grants from the current inputs and model pointers.
    task automatic eval();
        int c;
        #1;
        for (int b = 0; b < NB; b++) begin e_gch[b] = -1; e_ncand[b] = 0; end
        for (int k = 0; k < NC; k++) if (can_req(k)) e_ncand[bank_of(k)]++;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < NC; k++) begin
                c = (m_ptr[b] + k) % NC;
                if (e_gch[b] < 0 && can_req(c) && bank_of(c) == b) e_gch[b] = c;
            end
        end
        e_read = '0;
        for (int b = 0; b < NB; b++) if (e_gch[b] >= 0) e_read[e_gch[b]] = 1'b1;
    endtask

    // Clock edge: advance the model exactly as the spec's timing describes.
    task automatic advance();
        bit drained;
        eval();
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else begin
            drained = m_in_flush && (m_s1_v == '0) && (m_rv == '0);
            if (STATS)
                for (int b = 0; b < NB; b++)
                    if (!m_in_flush && e_ncand[b] >= 2 && m_cnt[b] < 65535) m_cnt[b]++;
            m_done = drained;
            m_rv   = m_s1_v;
            m_rb   = m_s1_b;
            for (int c = 0; c < NC; c++) begin
                m_s1_v[c] = e_read[c];
                m_s1_b[c] = e_read[c] ? bank_of(c) : 0;
            end
            for (int b = 0; b < NB; b++) begin
                m_en[b]   = (e_gch[b] >= 0);
                m_addr[b] = (e_gch[b] >= 0) ? off_of(e_gch[b]) : 0;
                if (e_gch[b] >= 0) m_ptr[b] = (e_gch[b] + 1) % NC;
            end
            if (m_in_flush) begin
                if (drained) begin
                    m_in_flush = 1'b0;
                    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
                end
            end else begin
                m_in_flush = flush;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; id = '0; id_fifo_empty = '1; vec_fifo_afull = '0; flush = 1'b0;
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic set_all_ids(input logic [COL_ID_SIZE-1:0] v);
        for (int c = 0; c < NC; c++) id[c*COL_ID_SIZE +: COL_ID_SIZE] = v;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        eval();
        n_cmp++; if (id_fifo_read !== '0) begin n_fail++; $display("FAIL reset_read got=%b exp=0", id_fifo_read); end
        n_cmp++; if (bank_en !== '0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", bank_en); end
        n_cmp++; if (bank_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bank_addr); end
        n_cmp++; if (route_valid !== '0) begin n_fail++; $display("FAIL reset_rv got=%b exp=0", route_valid); end
        n_cmp++; if (route_bank !== '0) begin n_fail++; $display("FAIL reset_rb got=%b exp=0", route_bank); end
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", flush_done); end
        n_cmp++; if (conflict_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    endtask

    task automatic test_basic();
        logic [3:0] t_read[5] = '{4'b0011, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] t_en[5]   = '{4'b0000, 4'b0011, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] t_rv[5]   = '{4'b0000, 4'b0000, 4'b0011, 4'b0100, 4'b1000};
        apply_reset();
        id = {10'h0FE, 10'h0FF, 10'h080, 10'h000};
        id_fifo_empty = '0;
        for (int k = 0; k < 5; k++) begin
            eval();
            n_cmp++; if (id_fifo_read !== t_read[k]) begin n_fail++; $display("FAIL basic_read cyc=%0d got=%b exp=%b", k, id_fifo_read, t_read[k]); end
            n_cmp++; if (bank_en !== t_en[k]) begin n_fail++; $display("FAIL basic_en cyc=%0d got=%b exp=%b", k, bank_en, t_en[k]); end
            n_cmp++; if (route_valid !== t_rv[k]) begin n_fail++; $display("FAIL basic_rv cyc=%0d got=%b exp=%b", k, route_valid, t_rv[k]); end
            n_cmp++; if (bank_addr !== exp_addr()) begin n_fail++; $display("FAIL basic_addr cyc=%0d got=%h exp=%h", k, bank_addr, exp_addr()); end
            n_cmp++; if (route_bank !== exp_rb()) begin n_fail++; $display("FAIL basic_rb cyc=%0d got=%b exp=%b", k, route_bank, exp_rb()); end
            advance();
            id_fifo_empty = id_fifo_empty | e_read;
        end
        // bank1 offsets seen at T+1..T+3 were 0x00, 0x7F, 0x7E; last is 0x7E held? no: addr now idle
        n_cmp++; if (bank_addr[BANK_LSB +: BANK_LSB] !== 7'h00) begin n_fail++; $display("FAIL basic_idle_addr got=%h exp=00", bank_addr[BANK_LSB +: BANK_LSB]); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        set_all_ids(10'h1FE);
        id_fifo_empty = '0;
        for (int k = 0; k < 5; k++) begin
            eval();
            n_cmp++; if (id_fifo_read !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rr_read cyc=%0d got=%b exp=%b", k, id_fifo_read, 4'b0001 << (k % 4)); end
            n_cmp++; if (conflict_cnt[3*CNT_W +: CNT_W] !== (STATS ? CNT_W'(k) : '0)) begin n_fail++; $display("FAIL rr_cnt cyc=%0d got=%0d exp=%0d", k, conflict_cnt[3*CNT_W +: CNT_W], STATS ? k : 0); end
            advance();
        end
        id_fifo_empty = '1;
        eval();
        n_cmp++; if (conflict_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rr_cnt_all got=%h exp=%h", conflict_cnt, exp_cnt()); end
    endtask

    task automatic test_parallel();
        apply_reset();
        id = {10'h180, 10'h100, 10'h080, 10'h000};
        id_fifo_empty = '0;
        eval();
        n_cmp++; if (id_fifo_read !== 4'b1111) begin n_fail++; $display("FAIL par_read got=%b exp=1111", id_fifo_read); end
        advance();
        id_fifo_empty = '1;
        eval();
        n_cmp++; if (bank_en !== 4'b1111) begin n_fail++; $display("FAIL par_en got=%b exp=1111", bank_en); end
        n_cmp++; if (bank_addr !== '0) begin n_fail++; $display("FAIL par_addr got=%h exp=0", bank_addr); end
        advance();
        eval();
        n_cmp++; if (route_valid !== 4'b1111) begin n_fail++; $display("FAIL par_rv got=%b exp=1111", route_valid); end
        n_cmp++; if (route_bank !== 8'b11100100) begin n_fail++; $display("FAIL par_rb got=%b exp=11100100", route_bank); end
        advance();
    endtask

    task automatic test_backpressure();
        apply_reset();
        id = {10'h000, 10'h000, 10'h080, 10'h000};
        id_fifo_empty  = 4'b1101;
        vec_fifo_afull = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            eval();
            n_cmp++; if (id_fifo_read !== 4'b0000) begin n_fail++; $display("FAIL bp_masked cyc=%0d got=%b exp=0000", k, id_fifo_read); end
            advance();
        end
        vec_fifo_afull = '0;
        eval();
        n_cmp++; if (id_fifo_read !== 4'b0010) begin n_fail++; $display("FAIL bp_release got=%b exp=0010", id_fifo_read); end
        advance();
        id_fifo_empty = '1;
        eval();
        n_cmp++; if (bank_en !== 4'b0010) begin n_fail++; $display("FAIL bp_en got=%b exp=0010", bank_en); end
        advance();
        eval();
        n_cmp++; if (route_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_rv got=%b exp=0010", route_valid); end
        n_cmp++; if (route_bank[BANK_BITS +: BANK_BITS] !== 2'd1) begin n_fail++; $display("FAIL bp_rb got=%0d exp=1", route_bank[BANK_BITS +: BANK_BITS]); end
        advance();
    endtask

    task automatic test_flush();
        bit seen;
        apply_reset();
        set_all_ids(10'h1FE);
        id_fifo_empty = '0;
        eval();
        n_cmp++; if (id_fifo_read !== 4'b0001) begin n_fail++; $display("FAIL fl_pre0 got=%b exp=0001", id_fifo_read); end
        advance();
        eval();
        n_cmp++; if (id_fifo_read !== 4'b0010) begin n_fail++; $display("FAIL fl_pre1 got=%b exp=0010", id_fifo_read); end
        advance();
        flush = 1'b1;
        eval();
        n_cmp++; if (id_fifo_read !== 4'b0000) begin n_fail++; $display("FAIL fl_cycle got=%b exp=0000", id_fifo_read); end
        advance();
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            flush = (k == 0);   // a second request inside FLUSH is ignored
            eval();
            if (flush_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                n_cmp++; if (id_fifo_read !== 4'b0000) begin n_fail++; $display("FAIL fl_nogrant k=%0d got=%b exp=0000", k, id_fifo_read); end
                n_cmp++; if (flush_done !== m_done) begin n_fail++; $display("FAIL fl_done_early k=%0d got=%b exp=%b", k, flush_done, m_done); end
                advance();
            end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL fl_timeout flush_done got=0 exp=1 within 3 cycles"); end
        if (seen) begin
            n_cmp++; if (id_fifo_read !== 4'b0001) begin n_fail++; $display("FAIL fl_ptr_reset got=%b exp=0001", id_fifo_read); end
            advance();
            eval();
            n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL fl_pulse_width got=%b exp=0", flush_done); end
        end
        id_fifo_empty = '1;
        advance();
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        id = '0;
        id_fifo_empty = 4'b1110;
        eval();
        n_cmp++; if (id_fifo_read !== 4'b0001) begin n_fail++; $display("FAIL rm_grant got=%b exp=0001", id_fifo_read); end
        advance();
        id_fifo_empty = 4'b1110;
        rst = 1'b1;
        eval();
        n_cmp++; if (id_fifo_read !== 4'b0000) begin n_fail++; $display("FAIL rm_read_in_rst got=%b exp=0000", id_fifo_read); end
        advance();
        rst = 1'b0;
        id_fifo_empty = '1;
        eval();
        n_cmp++; if (bank_en !== '0) begin n_fail++; $display("FAIL rm_en got=%b exp=0", bank_en); end
        n_cmp++; if (route_valid !== '0) begin n_fail++; $display("FAIL rm_rv got=%b exp=0", route_valid); end
        n_cmp++; if (bank_addr !== '0) begin n_fail++; $display("FAIL rm_addr got=%h exp=0", bank_addr); end
        advance();
        eval();
        n_cmp++; if (route_valid !== '0) begin n_fail++; $display("FAIL rm_rv_late got=%b exp=0", route_valid); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) id[c*COL_ID_SIZE +: COL_ID_SIZE] = COL_ID_SIZE'($urandom);
            id_fifo_empty  = NC'($urandom) & NC'($urandom);
            vec_fifo_afull = NC'($urandom) & NC'($urandom) & NC'($urandom);
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            eval();
            n_cmp++; if (id_fifo_read !== e_read) begin n_fail++; $display("FAIL rnd_read cyc=%0d got=%b exp=%b", i, id_fifo_read, e_read); end
            n_cmp++; if (bank_en !== m_en) begin n_fail++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", i, bank_en, m_en); end
            n_cmp++; if (bank_addr !== exp_addr()) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bank_addr, exp_addr()); end
            n_cmp++; if (route_valid !== m_rv) begin n_fail++; $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", i, route_valid, m_rv); end
            n_cmp++; if (route_bank !== exp_rb()) begin n_fail++; $display("FAIL rnd_rb cyc=%0d got=%b exp=%b", i, route_bank, exp_rb()); end
            n_cmp++; if (flush_done !== m_done) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, flush_done, m_done); end
            n_cmp++; if (conflict_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%h exp=%h", i, conflict_cnt, exp_cnt()); end
            advance();
        end
        rst = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset_model();
        rst = 1'b1; id = '0; id_fifo_empty = '1; vec_fifo_afull = '0; flush = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_parallel();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
